// File: rtl/c432_test_sequencer_if.sv
// Pattern-source and result-consumer handshakes of the c432 test sequencer.
interface c432_test_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             pat_valid;
  logic             pat_ready;
  logic [35:0]      pat_vec;
  logic [6:0]       pat_golden;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_index;
  logic [6:0]       res_obs;
  logic             res_mismatch;

  // Bench / system side: supplies vectors, consumes results.
  modport master (
    output pat_valid, pat_vec, pat_golden, res_ready,
    input  pat_ready, res_valid, res_index, res_obs, res_mismatch
  );

  // Sequencer side.
  modport slave (
    input  pat_valid, pat_vec, pat_golden, res_ready,
    output pat_ready, res_valid, res_index, res_obs, res_mismatch
  );
endinterface

// File: rtl/c432_test_sequencer.sv
// Test controller around the combinational c432 core: fetches vectors,
// drives them, waits a settle time, captures and compares the response,
// counts mismatches and compacts responses into a 7-bit MISR.
module c432_test_sequencer #(
  parameter int         SETTLE_CYCLES = 2,
  parameter int         CNT_W         = 16,
  parameter logic [6:0] MISR_POLY     = 7'h41
) (
  input  logic                 clk,
  input  logic                 rst,
  c432_test_sequencer_if.slave bus,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_patterns,
  output logic [35:0]          dut_in,
  input  logic [6:0]           dut_out,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     mismatch_count,
  output logic                 first_fail_valid,
  output logic [CNT_W-1:0]     first_fail_idx,
  output logic [6:0]           signature
);
  // A settle time of zero still needs one cycle for the core to respond.
  localparam int S  = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int SW = (S > 1) ? $clog2(S) : 1;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] FETCH   = 3'd1;
  localparam logic [2:0] APPLY   = 3'd2;
  localparam logic [2:0] CAPTURE = 3'd3;
  localparam logic [2:0] REPORT  = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  logic [2:0]       state;
  logic [SW-1:0]    settle;
  logic [6:0]       golden;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] num_lat;
  logic [CNT_W-1:0] idx_nxt;
  logic [6:0]       res_obs_q;
  logic             res_mm_q;
  logic             cap_mm;
  logic [6:0]       sig_nxt;

  assign idx_nxt = idx + CNT_W'(1);
  assign cap_mm  = (dut_out != golden);
  assign sig_nxt = {signature[5:0], 1'b0} ^ (signature[6] ? MISR_POLY : 7'h00) ^ dut_out;

  assign bus.pat_ready    = (state == FETCH);
  assign bus.res_valid    = (state == REPORT);
  assign bus.res_index    = idx;
  assign bus.res_obs      = res_obs_q;
  assign bus.res_mismatch = res_mm_q;
  assign busy             = (state != IDLE);
  assign done             = (state == DONE);

  // Sequencer FSM with its datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      settle           <= '0;
      golden           <= '0;
      idx              <= '0;
      num_lat          <= '0;
      dut_in           <= '0;
      res_obs_q        <= '0;
      res_mm_q         <= 1'b0;
      mismatch_count   <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
      signature        <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mismatch_count   <= '0;
          first_fail_valid <= 1'b0;
          first_fail_idx   <= '0;
          signature        <= '0;
          idx              <= '0;
          num_lat          <= num_patterns;
          state            <= (num_patterns == '0) ? DONE : FETCH;
        end
        FETCH: if (bus.pat_valid) begin
          dut_in <= bus.pat_vec;
          golden <= bus.pat_golden;
          settle <= SW'(S - 1);
          state  <= APPLY;
        end
        APPLY: begin
          if (settle == '0) state <= CAPTURE;
          else settle <= settle - SW'(1);
        end
        CAPTURE: begin
          res_obs_q <= dut_out;
          res_mm_q  <= cap_mm;
          signature <= sig_nxt;
          if (cap_mm) begin
            if (mismatch_count != '1) mismatch_count <= mismatch_count + CNT_W'(1);
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_idx   <= idx;
            end
          end
          state <= REPORT;
        end
        REPORT: if (bus.res_ready) begin
          idx   <= idx_nxt;
          state <= (idx_nxt == num_lat) ? DONE : FETCH;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
